logic_dispatch: RTL

LOGIC_DISPATCH -- requirements
Module: logic_dispatch

---
 rtl/logic_dispatch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/logic_dispatch.sv
// Single-issue dispatch stage: 8x32 register file, busy scoreboard with RAW/WAW
// stall, write-back bypass, and registered operand/op/tag outputs for a logic unit.
module logic_dispatch (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   output logic        in_ready,
   input  logic        wb_en,
   input  logic [2:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [2:0]  op,
   output logic [2:0]  out_rd,
   output logic [3:0]  pending
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 8;
   localparam int unsigned IDXW = 3;
   localparam int unsigned CNTW = 4;

   typedef struct packed {
      logic [IDXW-1:0] op;
      logic [IDXW-1:0] rd;
      logic [IDXW-1:0] rs1;
      logic [IDXW-1:0] rs2;
      logic [19:0]     spare;
   } instr_t;

   instr_t          instr;
   logic            unused_spare;

   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [CNTW-1:0] pending_q, pending_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [IDXW-1:0] op_q, op_d, out_rd_q, out_rd_d;

   logic [NREG-1:0] wb_mask;
   logic [NREG-1:0] busy_eff;
   logic            hazard;
   logic            accept;

   assign instr        = instr_t'(in_instr);
   assign unused_spare = ^instr.spare;

   // Hazard check sees the scoreboard as it will be once this cycle's write-back lands.
   always_comb begin
      wb_mask  = wb_en ? (NREG'(1) << wb_rd) : '0;
      busy_eff = busy_q & ~wb_mask;
      hazard   = busy_eff[instr.rs1] | busy_eff[instr.rs2] | busy_eff[instr.rd];
      in_ready = !rst && !hazard;
      accept   = in_valid && in_ready;
   end

   // Next-state: write-back first, so operand reads of rf_d get the bypassed value.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         rf_d[i] = rf_q[i];
      end
      busy_d      = busy_eff;
      out_valid_d = 1'b0;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      out_rd_d    = out_rd_q;
      pending_d   = '0;

      if (wb_en) begin
         rf_d[wb_rd] = wb_data;
      end

      if (accept) begin
         out_valid_d = 1'b1;
         a_d         = rf_d[instr.rs1];
         b_d         = rf_d[instr.rs2];
         op_d        = instr.op;
         out_rd_d    = instr.rd;
         busy_d      = busy_eff | (NREG'(1) << instr.rd);
      end

      for (int i = 0; i < NREG; i++) begin
         pending_d = pending_d + CNTW'(busy_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
         busy_q      <= '0;
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         out_rd_q    <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= rf_d[i];
         end
         busy_q      <= busy_d;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         out_rd_q    <= out_rd_d;
      end
   end

   assign out_valid = out_valid_q;
   assign a         = a_q;
   assign b         = b_q;
   assign op        = op_q;
   assign out_rd    = out_rd_q;
   assign pending   = pending_q;

endmodule
